// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame snapshot buffer.
package frame_pkg;

  localparam int unsigned PIXEL_W    = 12;
  localparam int unsigned NUM_PIXELS = 76800;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Marker pixel the sender expects at read address 0.
  localparam pixel_t START_PIXEL = 12'h00A;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } snap_state_t;

endpackage

// File: rtl/frame_snapshot_buffer_if.sv
// Camera stream, capture control and sender read port of the snapshot buffer.
interface frame_snapshot_buffer_if #(
  parameter int unsigned ADDR_W = 17
);
  import frame_pkg::*;

  logic              capture_req;
  logic              rd_lock;
  logic              pix_valid;
  logic              pix_sof;
  pixel_t            pix_data;
  logic [ADDR_W-1:0] rd_address;
  pixel_t            rd_pixel;
  logic              capture_busy;
  logic              frame_ready;
  logic              err_short_frame;

  modport master (
    output capture_req, rd_lock, pix_valid, pix_sof, pix_data, rd_address,
    input  rd_pixel, capture_busy, frame_ready, err_short_frame
  );

  modport slave (
    input  capture_req, rd_lock, pix_valid, pix_sof, pix_data, rd_address,
    output rd_pixel, capture_busy, frame_ready, err_short_frame
  );

endinterface

// File: rtl/frame_ram.sv
// Simple dual-port RAM, one write port and one registered read port, no array reset.
module frame_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 12,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Write and registered read; a same-address collision returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_snapshot_buffer.sv
// Captures one camera frame on request, freezes it, and serves it to the UART sender
// with a start marker at address 0 and a fixed two-cycle read latency.
module frame_snapshot_buffer #(
  parameter int unsigned       NUM_PIXELS  = frame_pkg::NUM_PIXELS,
  parameter int unsigned       ADDR_W      = 17,
  parameter frame_pkg::pixel_t START_PIXEL = frame_pkg::START_PIXEL
) (
  input logic                    clk,
  input logic                    rst_n,
  frame_snapshot_buffer_if.slave bus
);
  import frame_pkg::*;

  localparam int unsigned RamAw = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  typedef logic [RamAw-1:0] ram_addr_t;

  snap_state_t state_q, state_d;
  ram_addr_t   wr_cnt_q, wr_cnt_d;
  logic        frame_ready_q, frame_ready_d;
  logic        err_q, err_d;
  logic        rd_marker_q, rd_marker_d;
  logic        rd_oor_q, rd_oor_d;
  pixel_t      rd_pixel_q, rd_pixel_d;

  logic        ram_we;
  ram_addr_t   ram_waddr;
  ram_addr_t   ram_raddr;
  pixel_t      ram_rdata;

  frame_ram #(
    .Depth (NUM_PIXELS),
    .Width (PIXEL_W),
    .AddrW (RamAw)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (bus.pix_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Capture FSM: arm on request, start at SOF, restart on early SOF, freeze when full.
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    frame_ready_d = frame_ready_q;
    err_d         = err_q;
    ram_we        = 1'b0;
    ram_waddr     = wr_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        // Requests during rd_lock are dropped, not queued.
        if (bus.capture_req && !bus.rd_lock) begin
          state_d       = ARMED;
          frame_ready_d = 1'b0;
          err_d         = 1'b0;
          wr_cnt_d      = '0;
        end
      end
      ARMED: begin
        if (bus.pix_valid && bus.pix_sof) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
          wr_cnt_d  = RamAw'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.pix_valid) begin
          ram_we = 1'b1;
          if (bus.pix_sof) begin
            // Short frame: flag it and restart the capture from this pixel.
            err_d     = 1'b1;
            ram_waddr = '0;
            wr_cnt_d  = RamAw'(1);
          end else if (wr_cnt_q == RamAw'(NUM_PIXELS - 1)) begin
            state_d       = DONE;
            frame_ready_d = 1'b1;
            wr_cnt_d      = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + RamAw'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pipeline: stage 1 is the RAM read plus marker/range flags, stage 2 the output mux.
  always_comb begin
    rd_marker_d = (bus.rd_address == '0);
    rd_oor_d    = (bus.rd_address > ADDR_W'(NUM_PIXELS));
    // Address 0 and out-of-range addresses never index the array.
    ram_raddr   = (rd_marker_d || rd_oor_d) ? '0 : RamAw'(bus.rd_address - ADDR_W'(1));
    rd_pixel_d  = rd_marker_q ? START_PIXEL : (rd_oor_q ? '0 : ram_rdata);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      frame_ready_q <= 1'b0;
      err_q         <= 1'b0;
      rd_marker_q   <= 1'b0;
      rd_oor_q      <= 1'b0;
      rd_pixel_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      frame_ready_q <= frame_ready_d;
      err_q         <= err_d;
      rd_marker_q   <= rd_marker_d;
      rd_oor_q      <= rd_oor_d;
      rd_pixel_q    <= rd_pixel_d;
    end
  end

  assign bus.capture_busy    = (state_q == ARMED) || (state_q == CAPTURE);
  assign bus.frame_ready     = frame_ready_q;
  assign bus.err_short_frame = err_q;
  assign bus.rd_pixel        = rd_pixel_q;

endmodule

// File: tb/tb_frame_snapshot_buffer.sv
// Randomised self-checking bench for frame_snapshot_buffer with a small frame.
module tb_frame_snapshot_buffer;
  import frame_pkg::*;

  localparam int unsigned NP   = 16;
  localparam int unsigned AW   = 17;
  localparam logic [11:0] MARK = 12'h00A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: the frozen frame, status flags, and pixels collected since the last SOF.
  logic [11:0] m_mem [NP];
  bit          m_ready, m_err, m_armed, m_cap;
  logic [11:0] m_cur [$];

  always #10 clk = ~clk;

  frame_snapshot_buffer_if #(.ADDR_W(AW)) bus ();

  frame_snapshot_buffer #(
    .NUM_PIXELS  (NP),
    .ADDR_W      (AW),
    .START_PIXEL (MARK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [11:0] exp_rd(input int unsigned a);
    if (a == 0) return MARK;
    if (a > NP) return 12'h000;
    return m_mem[a-1];
  endfunction

  function automatic bit m_busy();
    return m_armed || m_cap;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input bit lock);
    bus.capture_req = 1'b1;
    bus.rd_lock     = lock;
    cycle();
    bus.capture_req = 1'b0;
    bus.rd_lock     = 1'b0;
    if (!lock && !m_busy()) begin
      m_armed = 1;
      m_ready = 0;
      m_err   = 0;
    end
  endtask

  task automatic put_pix(input bit sof, input logic [11:0] d);
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_data  = d;
    cycle();
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = 12'($urandom);
    if (m_armed) begin
      if (sof) begin
        m_armed = 0;
        m_cap   = 1;
        m_cur.delete();
        m_cur.push_back(d);
      end
    end else if (m_cap) begin
      if (sof) begin
        m_err = 1;
        m_cur.delete();
      end
      m_cur.push_back(d);
    end
    if (m_cap && m_cur.size() == NP) begin
      for (int i = 0; i < NP; i++) m_mem[i] = m_cur[i];
      m_cap   = 0;
      m_ready = 1;
    end
  endtask

  // Invalid cycles carry random data and a random SOF bit, which must be ignored.
  task automatic idle_gap(input int unsigned n);
    repeat (n) begin
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'($urandom);
      bus.pix_data  = 12'($urandom);
      cycle();
    end
    bus.pix_sof = 1'b0;
  endtask

  // Pipelined reads, one address per cycle; got[k] is the output two edges after addrs[k].
  task automatic read_burst(input int unsigned addrs[$], output logic [11:0] got[$]);
    got.delete();
    for (int i = 0; i <= addrs.size(); i++) begin
      if (i < addrs.size()) bus.rd_address = AW'(addrs[i]);
      else bus.rd_address = AW'($urandom_range(0, NP + 3));
      cycle();
      if (i >= 1) got.push_back(bus.rd_pixel);
    end
  endtask

  task automatic test_reset();
    m_ready = 0; m_err = 0; m_armed = 0; m_cap = 0;
    m_cur.delete();
    rst_n           = 1'b0;
    bus.capture_req = 1'b1;
    bus.rd_lock     = 1'b0;
    bus.pix_valid   = 1'b1;
    bus.pix_sof     = 1'b1;
    bus.pix_data    = 12'h5A5;
    bus.rd_address  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_run++;
    if (bus.rd_pixel !== 12'h000) begin
      n_fail++; $display("FAIL reset_rd_pixel got=%h exp=000", bus.rd_pixel);
    end
    n_run++;
    if (bus.capture_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.capture_busy);
    end
    n_run++;
    if (bus.frame_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.frame_ready);
    end
    n_run++;
    if (bus.err_short_frame !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got=%b exp=0", bus.err_short_frame);
    end
    bus.capture_req = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_sof     = 1'b0;
    rst_n           = 1'b1;
    cycle();
    for (int k = 0; k < NP + 4; k++) begin
      put_pix(k == 0, 12'($urandom));
      idle_gap($urandom_range(0, 1));
      n_run++;
      if (bus.frame_ready !== 1'b0 || bus.capture_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_req_stream k=%0d ready=%b busy=%b exp=0/0", k, bus.frame_ready,
                 bus.capture_busy);
      end
    end
  endtask

  task automatic test_basic_capture();
    int unsigned addrs[$];
    logic [11:0] got[$];
    request(0);
    n_run++;
    if (bus.capture_busy !== 1'b1 || bus.frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_armed busy=%b ready=%b exp=1/0", bus.capture_busy, bus.frame_ready);
    end
    for (int k = 0; k < NP; k++) begin
      if (k > 0) idle_gap($urandom_range(0, 2));
      put_pix(k == 0, 12'h100 + 12'(k));
      n_run++;
      if (bus.capture_busy !== m_busy() || bus.frame_ready !== m_ready) begin
        n_fail++;
        $display("FAIL basic_stream k=%0d busy=%b ready=%b exp=%b/%b", k, bus.capture_busy,
                 bus.frame_ready, m_busy(), m_ready);
      end
    end
    // Pixels after completion must not disturb the frozen frame.
    put_pix(1, 12'hBAD);
    put_pix(0, 12'hBAD);
    n_run++;
    if (bus.frame_ready !== 1'b1 || bus.capture_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done ready=%b busy=%b exp=1/0", bus.frame_ready, bus.capture_busy);
    end
    for (int a = 0; a <= NP + 1; a++) addrs.push_back(a);
    addrs.push_back((1 << AW) - 1);
    read_burst(addrs, got);
    foreach (addrs[k]) begin
      n_run++;
      if (got[k] !== exp_rd(addrs[k])) begin
        n_fail++;
        $display("FAIL basic_read addr=%0d got=%h exp=%h", addrs[k], got[k], exp_rd(addrs[k]));
      end
    end
  endtask

  task automatic test_pre_sof();
    int unsigned addrs[$];
    logic [11:0] got[$];
    request(0);
    repeat (3) put_pix(0, 12'hFFF);
    request(0);
    n_run++;
    if (bus.capture_busy !== 1'b1 || bus.frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL presof_armed busy=%b ready=%b exp=1/0", bus.capture_busy, bus.frame_ready);
    end
    for (int k = 0; k < NP; k++) begin
      put_pix(k == 0, 12'h200 + 12'(k));
      idle_gap($urandom_range(0, 1));
    end
    n_run++;
    if (bus.frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL presof_ready got=%b exp=1", bus.frame_ready);
    end
    for (int a = 0; a <= NP; a++) addrs.push_back(a);
    read_burst(addrs, got);
    foreach (addrs[k]) begin
      n_run++;
      if (got[k] !== exp_rd(addrs[k])) begin
        n_fail++;
        $display("FAIL presof_read addr=%0d got=%h exp=%h", addrs[k], got[k], exp_rd(addrs[k]));
      end
    end
  endtask

  task automatic test_short_frame();
    int unsigned addrs[$];
    logic [11:0] got[$];
    request(0);
    for (int k = 0; k < 5; k++) put_pix(k == 0, 12'h300 + 12'(k));
    for (int k = 0; k < NP; k++) begin
      put_pix(k == 0, 12'($urandom));
      if (k == 0) begin
        n_run++;
        if (bus.err_short_frame !== 1'b1 || bus.capture_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL short_err err=%b busy=%b exp=1/1", bus.err_short_frame,
                   bus.capture_busy);
        end
      end
      idle_gap($urandom_range(0, 1));
    end
    n_run++;
    if (bus.frame_ready !== 1'b1 || bus.err_short_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL short_done ready=%b err=%b exp=1/1", bus.frame_ready, bus.err_short_frame);
    end
    for (int a = 0; a <= NP; a++) addrs.push_back(a);
    read_burst(addrs, got);
    foreach (addrs[k]) begin
      n_run++;
      if (got[k] !== exp_rd(addrs[k])) begin
        n_fail++;
        $display("FAIL short_read addr=%0d got=%h exp=%h", addrs[k], got[k], exp_rd(addrs[k]));
      end
    end
  endtask

  task automatic test_lock();
    int unsigned addrs[$];
    logic [11:0] got[$];
    request(1);
    n_run++;
    if (bus.capture_busy !== 1'b0 || bus.frame_ready !== 1'b1 || bus.err_short_frame !== 1'b1)
    begin
      n_fail++;
      $display("FAIL lock_drop busy=%b ready=%b err=%b exp=0/1/1", bus.capture_busy,
               bus.frame_ready, bus.err_short_frame);
    end
    for (int k = 0; k < 4; k++) put_pix(k == 0, 12'hEEE);
    for (int a = 1; a <= NP; a++) addrs.push_back(a);
    read_burst(addrs, got);
    foreach (addrs[k]) begin
      n_run++;
      if (got[k] !== exp_rd(addrs[k])) begin
        n_fail++;
        $display("FAIL lock_read addr=%0d got=%h exp=%h", addrs[k], got[k], exp_rd(addrs[k]));
      end
    end
    request(0);
    n_run++;
    if (bus.capture_busy !== 1'b1 || bus.frame_ready !== 1'b0 || bus.err_short_frame !== 1'b0)
    begin
      n_fail++;
      $display("FAIL lock_accept busy=%b ready=%b err=%b exp=1/0/0", bus.capture_busy,
               bus.frame_ready, bus.err_short_frame);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned addrs[$];
    logic [11:0] got[$];
    for (int k = 0; k < 8; k++) put_pix(k == 0, 12'h400 + 12'(k));
    rst_n = 1'b0;
    #1;
    m_ready = 0; m_err = 0; m_armed = 0; m_cap = 0;
    n_run++;
    if (bus.frame_ready !== 1'b0 || bus.capture_busy !== 1'b0 || bus.rd_pixel !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset ready=%b busy=%b rd=%h exp=0/0/000", bus.frame_ready,
               bus.capture_busy, bus.rd_pixel);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    addrs.push_back(0);
    addrs.push_back(NP + 1);
    addrs.push_back(0);
    read_burst(addrs, got);
    foreach (addrs[k]) begin
      n_run++;
      if (got[k] !== exp_rd(addrs[k])) begin
        n_fail++;
        $display("FAIL midreset_read addr=%0d got=%h exp=%h", addrs[k], got[k],
                 exp_rd(addrs[k]));
      end
    end
    for (int k = 0; k < NP; k++) put_pix(k == 0, 12'($urandom));
    n_run++;
    if (bus.frame_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle ready=%b exp=0", bus.frame_ready);
    end
  endtask

  task automatic test_random();
    int unsigned addrs[$];
    logic [11:0] got[$];
    for (int it = 0; it < 4; it++) begin
      request(0);
      repeat ($urandom_range(0, 3)) put_pix(0, 12'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        put_pix(1, 12'($urandom));
        repeat ($urandom_range(0, NP - 3)) begin
          idle_gap($urandom_range(0, 1));
          put_pix(0, 12'($urandom));
        end
        request(0);
      end
      for (int k = 0; k < NP; k++) begin
        put_pix(k == 0, 12'($urandom));
        idle_gap($urandom_range(0, 2));
      end
      n_run++;
      if (bus.frame_ready !== m_ready || bus.capture_busy !== m_busy() ||
          bus.err_short_frame !== m_err) begin
        n_fail++;
        $display("FAIL rand_status it=%0d ready=%b busy=%b err=%b exp=%b/%b/%b", it,
                 bus.frame_ready, bus.capture_busy, bus.err_short_frame, m_ready, m_busy(),
                 m_err);
      end
      addrs.delete();
      repeat (24) addrs.push_back($urandom_range(0, NP + 3));
      read_burst(addrs, got);
      foreach (addrs[k]) begin
        n_run++;
        if (got[k] !== exp_rd(addrs[k])) begin
          n_fail++;
          $display("FAIL rand_read it=%0d addr=%0d got=%h exp=%h", it, addrs[k], got[k],
                   exp_rd(addrs[k]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_pre_sof();
    test_short_frame();
    test_lock();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
